stream_to_memory: RTL and testbench

Deserializer for the posit dataflow: accepts a serial stream of words over the rts/rtr/eow handshake and packs them into a MEMORY_DEPTH-entry register bank. Once the bank holds one complete frame, it is presented in parallel to a downstream consumer, for example an argmax or classification stage. It is the receiving counterpart of memory_to_stream and sits after a positron layer's serial output. A frame ends either at MEMORY_DEPTH words or early on eow_i (DMA tlast); in both cases the bank is held until the consumer takes it.

---
 rtl/posit_defines.sv | 11 +
 rtl/stream_to_memory.sv | 121 ++++++++++++
 tb/tb_stream_to_memory.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/posit_defines.sv
// Shared typedefs for the posit dataflow stream blocks.
package posit_defines;

    // Deserializer state: filling the bank from the serial side, or
    // holding a complete frame for the parallel consumer.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } stream_state_t;

endpackage : posit_defines

// File: rtl/stream_to_memory.sv
// stream_to_memory: packs a serial rts/rtr/eow word stream into a
// MEMORY_DEPTH-entry register bank and presents the completed frame in
// parallel. A frame ends at MEMORY_DEPTH words or early on eow_i. The bank
// is held until the consumer takes it, then cleared in one cycle.
module stream_to_memory
    import posit_defines::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 20
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    // serial slave side
    output logic                                   rtr_o,
    input  logic                                   rts_i,
    input  logic                                   eow_i,
    input  logic [DATA_WIDTH-1:0]                  data_i,
    // parallel master side
    input  logic                                   rtr_i,
    output logic                                   rts_o,
    output logic                                   eow_o,
    output logic [$clog2(MEMORY_DEPTH+1)-1:0]      count_o,
    output logic [MEMORY_DEPTH-1:0][DATA_WIDTH-1:0] data_o
);

    localparam int WP_W  = $clog2(MEMORY_DEPTH);
    localparam int CNT_W = $clog2(MEMORY_DEPTH + 1);
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(MEMORY_DEPTH - 1);

    stream_state_t                           state;
    stream_state_t                           state_next;
    logic [WP_W-1:0]                         wp;
    logic [CNT_W-1:0]                        count;
    logic                                    eow_held;
    logic [MEMORY_DEPTH-1:0][DATA_WIDTH-1:0] bank;

    logic accept;
    logic release_bank;
    logic last_word;

    // Handshakes are qualified by the registered state, so rtr_o/rts_o
    // never depend combinationally on an input.
    assign accept       = rts_i && (state == FILL);
    assign release_bank = rtr_i && (state == HOLD);
    // eow on the final slot completes a single frame; no empty frame follows.
    assign last_word    = eow_i || (wp == WP_LAST);

    assign count_o = count;
    assign eow_o   = eow_held;
    assign data_o  = bank;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state only.
    always_comb begin
        state_next = state;
        rtr_o      = 1'b0;
        rts_o      = 1'b0;
        case (state)
            FILL: begin
                rtr_o = 1'b1;
                if (accept && last_word) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                rts_o = 1'b1;
                if (release_bank) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Write pointer, frame length and early-termination flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            count    <= '0;
            eow_held <= 1'b0;
        end else if (accept) begin
            if (last_word) begin
                wp       <= '0;
                count    <= CNT_W'(wp) + CNT_W'(1);
                eow_held <= eow_i;
            end else begin
                wp <= wp + WP_W'(1);
            end
        end else if (release_bank) begin
            count    <= '0;
            eow_held <= 1'b0;
        end
    end

    // Register bank: per-entry write enable from wp decode, global clear on
    // release so slots beyond a short frame read as zero next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (release_bank) begin
            bank <= '0;
        end else if (accept) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                if (wp == WP_W'(i)) begin
                    bank[i] <= data_i;
                end
            end
        end
    end

endmodule : stream_to_memory

// File: tb/tb_stream_to_memory.sv
// Directed bench for stream_to_memory with DATA_WIDTH=16, MEMORY_DEPTH=4.
module tb_stream_to_memory;

    localparam int DW = 16;
    localparam int MD = 4;
    localparam int CW = $clog2(MD + 1);

    logic                      clk;
    logic                      rst_n;
    logic                      rtr_o;
    logic                      rts_i;
    logic                      eow_i;
    logic [DW-1:0]             data_i;
    logic                      rtr_i;
    logic                      rts_o;
    logic                      eow_o;
    logic [CW-1:0]             count_o;
    logic [MD-1:0][DW-1:0]     data_o;

    int n_cmp;
    int n_err;

    stream_to_memory #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (MD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rtr_o   (rtr_o),
        .rts_i   (rts_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .eow_o   (eow_o),
        .count_o (count_o),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        int            reps;
        logic          rts;
        logic          eow;
        logic [DW-1:0] din;
        logic          rtr;
        logic          e_rtr;
        logic          e_rts;
        logic          e_eow;
        logic [CW-1:0] e_cnt;
        logic [63:0]   e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int reps,
                       input logic rts, input logic eow, input logic [DW-1:0] din,
                       input logic rtr, input logic e_rtr, input logic e_rts,
                       input logic e_eow, input logic [CW-1:0] e_cnt,
                       input logic [63:0] e_data);
        vec_t v;
        v.name = name; v.reps = reps; v.rts = rts; v.eow = eow; v.din = din;
        v.rtr = rtr; v.e_rtr = e_rtr; v.e_rts = e_rts; v.e_eow = e_eow;
        v.e_cnt = e_cnt; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic e_rtr, input logic e_rts,
                         input logic e_eow, input logic [CW-1:0] e_cnt,
                         input logic [63:0] e_data);
        logic [63:0] act;
        act = data_o;
        n_cmp++;
        if (rtr_o !== e_rtr || rts_o !== e_rts || eow_o !== e_eow ||
            count_o !== e_cnt || act !== e_data) begin
            n_err++;
            $display("FAIL %s: got rtr=%b rts=%b eow=%b cnt=%0d data=%h, want rtr=%b rts=%b eow=%b cnt=%0d data=%h",
                     name, rtr_o, rts_o, eow_o, count_o, act,
                     e_rtr, e_rts, e_eow, e_cnt, e_data);
        end
    endtask

    task automatic step(input logic rts, input logic eow, input logic [DW-1:0] din,
                        input logic rtr);
        rts_i = rts; eow_i = eow; data_i = din; rtr_i = rtr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rts_i = 0; eow_i = 0; data_i = '0; rtr_i = 0;
        rst_n = 0;
        #2;
        check("reset_async", 1, 0, 0, 0, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("reset_idle", 1, 0, 0, 0, 64'h0);

        // full frame
        add("full_w0", 1, 1, 0, 16'h1111, 0, 1, 0, 0, 0, 64'h0000_0000_0000_1111);
        add("full_w1", 1, 1, 0, 16'h2222, 0, 1, 0, 0, 0, 64'h0000_0000_2222_1111);
        add("full_w2", 1, 1, 0, 16'h3333, 0, 1, 0, 0, 0, 64'h0000_3333_2222_1111);
        add("full_w3", 1, 1, 0, 16'h4444, 0, 0, 1, 0, 4, 64'h4444_3333_2222_1111);
        // back-pressure, then release and accept the waiting word
        add("bp_hold", 10, 1, 0, 16'h5555, 0, 0, 1, 0, 4, 64'h4444_3333_2222_1111);
        add("bp_release", 1, 1, 0, 16'h5555, 1, 1, 0, 0, 0, 64'h0);
        add("bp_accept", 1, 1, 0, 16'h5555, 0, 1, 0, 0, 0, 64'h0000_0000_0000_5555);
        add("bp_eow", 1, 1, 1, 16'h6666, 0, 0, 1, 1, 2, 64'h0000_0000_6666_5555);
        add("bp_rel2", 1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 64'h0);
        // short frame; HOLD ignores rts_i, release edge does not accept
        add("short_w0", 1, 1, 0, 16'hAAAA, 0, 1, 0, 0, 0, 64'h0000_0000_0000_AAAA);
        add("short_w1", 1, 1, 1, 16'hBBBB, 0, 0, 1, 1, 2, 64'h0000_0000_BBBB_AAAA);
        add("short_ign", 2, 1, 0, 16'hCCCC, 0, 0, 1, 1, 2, 64'h0000_0000_BBBB_AAAA);
        add("short_rel", 1, 1, 0, 16'hCCCC, 1, 1, 0, 0, 0, 64'h0);
        add("fill_rtr", 1, 0, 0, 16'hCCCC, 1, 1, 0, 0, 0, 64'h0);
        // eow on the last slot
        add("last_w0", 1, 1, 0, 16'h0101, 0, 1, 0, 0, 0, 64'h0000_0000_0000_0101);
        add("last_w1", 1, 1, 0, 16'h0202, 0, 1, 0, 0, 0, 64'h0000_0000_0202_0101);
        add("last_w2", 1, 1, 0, 16'h0303, 0, 1, 0, 0, 0, 64'h0000_0303_0202_0101);
        add("last_w3", 1, 1, 1, 16'h0404, 0, 0, 1, 1, 4, 64'h0404_0303_0202_0101);
        add("last_rel", 1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 64'h0);
        add("last_idle", 2, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 64'h0);
        // gapped input; idle cycles carry junk data and eow that must be ignored
        add("gap_c0", 1, 1, 0, 16'h00A1, 0, 1, 0, 0, 0, 64'h0000_0000_0000_00A1);
        add("gap_c1", 1, 0, 1, 16'hFFFF, 0, 1, 0, 0, 0, 64'h0000_0000_0000_00A1);
        add("gap_c2", 1, 1, 0, 16'h00A2, 0, 1, 0, 0, 0, 64'h0000_0000_00A2_00A1);
        add("gap_c3", 1, 0, 1, 16'hFFFF, 0, 1, 0, 0, 0, 64'h0000_0000_00A2_00A1);
        add("gap_c4", 1, 1, 0, 16'h00A3, 0, 1, 0, 0, 0, 64'h0000_00A3_00A2_00A1);
        add("gap_c5", 1, 0, 1, 16'hFFFF, 0, 1, 0, 0, 0, 64'h0000_00A3_00A2_00A1);
        add("gap_c6", 1, 1, 0, 16'h00A4, 0, 0, 1, 0, 4, 64'h00A4_00A3_00A2_00A1);
        add("gap_c7", 1, 0, 0, 16'hFFFF, 0, 0, 1, 0, 4, 64'h00A4_00A3_00A2_00A1);
        add("gap_rel", 1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 64'h0);

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                step(vecs[k].rts, vecs[k].eow, vecs[k].din, vecs[k].rtr);
                check(vecs[k].name, vecs[k].e_rtr, vecs[k].e_rts, vecs[k].e_eow,
                      vecs[k].e_cnt, vecs[k].e_data);
            end
        end

        // mid-frame asynchronous reset
        step(1, 0, 16'hE001, 0);
        step(1, 0, 16'hE002, 0);
        check("mid_pre", 1, 0, 0, 0, 64'h0000_0000_E002_E001);
        rts_i = 0;
        #2;
        rst_n = 0;
        #1;
        check("mid_async", 1, 0, 0, 0, 64'h0);
        @(posedge clk); #1;
        check("mid_held", 1, 0, 0, 0, 64'h0);
        #3;
        rst_n = 1;
        @(posedge clk); #1;
        step(1, 0, 16'hD000, 0);
        step(1, 0, 16'hD001, 0);
        step(1, 0, 16'hD002, 0);
        check("mid_partial", 1, 0, 0, 0, 64'h0000_D002_D001_D000);
        step(1, 0, 16'hD003, 0);
        check("mid_frame", 0, 1, 0, 4, 64'hD003_D002_D001_D000);
        step(0, 0, 16'h0000, 1);
        check("mid_rel", 1, 0, 0, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_stream_to_memory
